// File: rtl/control_mem_vectorial_pkg.sv
// Shared types and defaults for the vector MEM-stage sequencer.
package pkg_vectorial;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int REG_ADDR_W = 3;
    localparam int N_ELEM_DEF = 4;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/control_mem_vectorial_gen_dir_vec.sv
// Element address accumulator: loads base (and stride), then adds stride per step.
module gen_dir_vec #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              step,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;

    // Stride is captured with base so the walk cannot be disturbed by upstream changes.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load) begin
            addr_d   = base;
            stride_d = stride;
        end else if (step) begin
            addr_d = addr_q + stride_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/control_mem_vectorial.sv
// MEM-stage sequencer: issues one memory access per element and returns load data.
module control_mem_vectorial
    import pkg_vectorial::*;
#(
    parameter int N_ELEM = N_ELEM_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int IDX_W = idx_width(N_ELEM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic                     op_vec,
    input  logic                     op_wr,
    input  logic [ADDR_W-1:0]        op_base,
    input  logic [ADDR_W-1:0]        op_stride,
    input  logic [REG_ADDR_W-1:0]    op_dest,
    input  logic [DATA_W*N_ELEM-1:0] op_wdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_gnt,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     wb_valid,
    output logic [REG_ADDR_W-1:0]    wb_dest,
    output logic [IDX_W-1:0]         wb_idx,
    output logic [DATA_W-1:0]        wb_data,
    output logic                     stall,
    output logic                     done
);

    state_e                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic [REG_ADDR_W-1:0]   dest_q, dest_d;
    logic [DATA_W*N_ELEM-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0]   wb_dest_q, wb_dest_d;
    logic [IDX_W-1:0]        wb_idx_q, wb_idx_d;
    logic [DATA_W-1:0]       wb_data_q, wb_data_d;

    logic accept;
    logic gnt_busy;

    assign accept   = (state_q == ST_IDLE) && op_valid;
    assign gnt_busy = (state_q == ST_BUSY) && mem_gnt;

    // last_q holds count-1 so the terminal compare is against the current index.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        dest_d     = dest_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        last_d     = last_q;
        wb_valid_d = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_idx_d   = wb_idx_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    state_d = ST_BUSY;
                    wr_d    = op_wr;
                    dest_d  = op_dest;
                    wdata_d = op_wdata;
                    idx_d   = '0;
                    last_d  = op_vec ? IDX_W'(N_ELEM - 1) : '0;
                end
            end
            ST_BUSY: begin
                if (mem_gnt) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == last_q) state_d = ST_DONE;
                    if (!wr_q) begin
                        wb_valid_d = 1'b1;
                        wb_dest_d  = dest_q;
                        wb_idx_d   = idx_q;
                        wb_data_d  = mem_rdata;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            dest_q     <= '0;
            wdata_q    <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            dest_q     <= dest_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            wb_idx_q   <= wb_idx_d;
            wb_data_q  <= wb_data_d;
        end
    end

    gen_dir_vec #(.ADDR_W(ADDR_W)) u_gen_dir_vec (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .base   (op_base),
        .stride (op_stride),
        .step   (gnt_busy),
        .addr   (mem_addr)
    );

    assign op_ready  = (state_q == ST_IDLE);
    assign stall     = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_req   = (state_q == ST_BUSY);
    assign mem_we    = (state_q == ST_BUSY) && wr_q;
    assign mem_wdata = wdata_q[int'(idx_q)*DATA_W +: DATA_W];
    assign wb_valid  = wb_valid_q;
    assign wb_dest   = wb_dest_q;
    assign wb_idx    = wb_idx_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_control_mem_vectorial.sv
// Randomized and directed bench for control_mem_vectorial against a per-element access model.
module tb_control_mem_vectorial;
    import pkg_vectorial::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            op_valid, op_vec, op_wr;
    logic [AW-1:0]   op_base, op_stride;
    logic [2:0]      op_dest;
    logic [DW*N-1:0] op_wdata;
    logic            op_ready;
    logic            mem_req, mem_we, mem_gnt;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            wb_valid, stall, done;
    logic [2:0]      wb_dest;
    logic [IW-1:0]   wb_idx;
    logic [DW-1:0]   wb_data;

    int vectors = 0;
    int miscompares = 0;

    control_mem_vectorial #(.N_ELEM(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_vec(op_vec), .op_wr(op_wr),
        .op_base(op_base), .op_stride(op_stride), .op_dest(op_dest), .op_wdata(op_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_idx(wb_idx), .wb_data(wb_data),
        .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the ready cycle.
    task automatic run_op(input logic vec, input logic wr, input logic [AW-1:0] base,
                          input logic [AW-1:0] stride, input logic [2:0] dest,
                          input logic [DW*N-1:0] wdata, input int stall_elem,
                          input int stall_cycles, input bit rand_gnt, input bit hold_valid,
                          input bit rand_rdata, input logic [DW-1:0] rdata_base);
        int count, i, stalled, cyc;
        bit pend_wb, first, g;
        logic [DW-1:0] exp_wb_data;
        logic [IW-1:0] exp_wb_idx;
        logic [AW-1:0] exp_addr;
        count = vec ? N : 1;
        chk("idle_ready", op_ready, 1);
        chk("idle_stall", stall, 0);
        chk("idle_wb_valid", wb_valid, 0);
        op_valid = 1'b1; op_vec = vec; op_wr = wr; op_base = base;
        op_stride = stride; op_dest = dest; op_wdata = wdata;
        i = 0; stalled = 0; cyc = 0; pend_wb = 0; first = 1;
        exp_wb_data = '0; exp_wb_idx = '0;
        while (i < count) begin
            @(negedge clk);
            if (first) begin
                first = 0;
                if (hold_valid) begin
                    op_base = base ^ 8'h5A; op_vec = 1'b0; op_wr = 1'b0;
                end else begin
                    op_valid = 1'b0;
                end
            end
            exp_addr = AW'(int'(base) + i * int'(stride));
            chk("busy_req", mem_req, 1);
            chk("busy_stall", stall, 1);
            chk("busy_ready", op_ready, 0);
            chk("busy_done", done, 0);
            chk("busy_addr", mem_addr, exp_addr);
            chk("busy_we", mem_we, wr);
            chk("busy_wdata", mem_wdata, wdata[i*DW +: DW]);
            chk("busy_wb_valid", wb_valid, pend_wb);
            if (pend_wb) begin
                chk("wb_data", wb_data, exp_wb_data);
                chk("wb_idx", wb_idx, exp_wb_idx);
                chk("wb_dest", wb_dest, dest);
            end
            if (i == stall_elem && stalled < stall_cycles) begin
                g = 0; stalled++;
            end else if (rand_gnt) g = ($urandom_range(0, 3) != 0);
            else g = 1;
            mem_gnt = g;
            mem_rdata = rand_rdata ? DW'($urandom) : rdata_base + DW'(i);
            pend_wb = g && !wr;
            if (g) begin
                exp_wb_data = mem_rdata;
                exp_wb_idx = IW'(i);
                i++;
            end
            cyc++;
            if (cyc > 200) begin
                chk("grant_timeout", 1, 0);
                break;
            end
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_req", mem_req, 0);
        chk("done_ready", op_ready, 0);
        chk("done_wb_valid", wb_valid, pend_wb);
        if (pend_wb) begin
            chk("last_wb_data", wb_data, exp_wb_data);
            chk("last_wb_idx", wb_idx, exp_wb_idx);
        end
        @(negedge clk);
        chk("ret_ready", op_ready, 1);
        chk("ret_done", done, 0);
        chk("ret_stall", stall, 0);
        chk("ret_wb_valid", wb_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 0; op_vec = 0; op_wr = 0; op_base = '0;
        op_stride = '0; op_dest = '0; op_wdata = '0; mem_gnt = 0; mem_rdata = '0;
        #3;
        chk("rst_ready", op_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wb", {wb_valid, wb_dest, wb_idx, wb_data}, 0);
        chk("rst_stall_done", {stall, done, mem_we}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 0, 8'h10, 8'h00, 3'd5, '0, -1, 0, 0, 0, 0, 32'hCAFE0001);
        run_op(1, 1, 8'h20, 8'h04, 3'd1, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0},
               -1, 0, 0, 0, 1, 0);
        run_op(1, 0, 8'h20, 8'h04, 3'd6, '0, 1, 2, 0, 0, 1, 0);
        run_op(1, 0, 8'hFC, 8'h04, 3'd2, '0, -1, 0, 0, 0, 1, 0);
        run_op(1, 1, 8'h30, 8'h10, 3'd3, {4{32'h12345678}}, -1, 0, 0, 1, 1, 0);
        run_op(0, 0, 8'h30 ^ 8'h5A, 8'h10, 3'd3, {4{32'h12345678}}, -1, 0, 0, 0, 1, 0);

        // Reset in the middle of a vector load, at element 2.
        op_valid = 1; op_vec = 1; op_wr = 0; op_base = 8'h40; op_stride = 8'h08; op_dest = 3'd7;
        @(negedge clk); op_valid = 0; mem_gnt = 1; mem_rdata = 32'h11;
        @(negedge clk); mem_rdata = 32'h22;
        @(negedge clk);
        chk("pre_rst_addr", mem_addr, 8'h50);
        chk("pre_rst_wb_valid", wb_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", mem_req, 0);
        chk("async_stall", stall, 0);
        chk("async_wb_valid", wb_valid, 0);
        chk("async_ready", op_ready, 1);
        @(negedge clk);
        mem_gnt = 0; rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 0, 8'h77, 8'h01, 3'd4, '0, -1, 0, 0, 0, 0, 32'h0BADF00D);

        for (int k = 0; k < 25; k++) begin
            run_op(1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom), 3'($urandom),
                   {$urandom, $urandom, $urandom, $urandom}, -1, 0, 1, 0, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
